// File: rtl/pong_game_controller.sv
// Pong match sequencer: match state, scores, serve timing and direction.
// Optional win-by-two rule with deuce clamp: define PONG_WIN_BY_TWO_EN.
module pong_game_controller #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_PAUSE = 30
) (
    input  logic               CLOCK_25,
    input  logic               RESET_N,
    input  logic               tick,
    input  logic               start,
    input  logic               miss_1,
    input  logic               miss_2,
    output logic               ball_reload,
    output logic               ball_run,
    output logic               serve_left,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int SERVE_LD = (SERVE_DELAY < 1) ? 1 : SERVE_DELAY;
    localparam int PAUSE_LD = (POINT_PAUSE < 1) ? 1 : POINT_PAUSE;
    localparam int CNT_MAX  = (SERVE_LD > PAUSE_LD) ? SERVE_LD : PAUSE_LD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_LD);
    localparam logic [CNT_W-1:0]   PAUSE_CNT = CNT_W'(PAUSE_LD);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   cnt;
    logic               start_q;
    logic               start_edge;
    logic [SCORE_W-1:0] inc_1;
    logic [SCORE_W-1:0] inc_2;
    logic [SCORE_W-1:0] nxt_1;
    logic [SCORE_W-1:0] nxt_2;
    logic               win_1;
    logic               win_2;

    assign state      = st;
    assign start_edge = start & ~start_q;

    // A simultaneous double miss is a replay: neither score moves.
    always_comb begin
        inc_1 = score_1 + {{(SCORE_W-1){1'b0}}, miss_2 & ~miss_1};
        inc_2 = score_2 + {{(SCORE_W-1){1'b0}}, miss_1 & ~miss_2};
        nxt_1 = inc_1;
        nxt_2 = inc_2;
`ifdef PONG_WIN_BY_TWO_EN
        if (inc_1 == inc_2 && inc_1 >= SCORE_W'(WIN_SCORE - 1)) begin
            nxt_1 = SCORE_W'(WIN_SCORE - 1);
            nxt_2 = SCORE_W'(WIN_SCORE - 1);
        end
        win_1 = (score_1 >= WIN) &&
                ({1'b0, score_1} >= {1'b0, score_2} + (SCORE_W+1)'(2));
        win_2 = (score_2 >= WIN) &&
                ({1'b0, score_2} >= {1'b0, score_1} + (SCORE_W+1)'(2));
`else
        win_1 = (score_1 == WIN);
        win_2 = (score_2 == WIN);
`endif
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            st          <= IDLE;
            cnt         <= '0;
            start_q     <= 1'b0;
            score_1     <= '0;
            score_2     <= '0;
            ball_reload <= 1'b0;
            ball_run    <= 1'b0;
            serve_left  <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            start_q     <= start;
            ball_reload <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (start_edge) begin
                        score_1     <= '0;
                        score_2     <= '0;
                        ball_reload <= 1'b1;
                        cnt         <= SERVE_CNT;
                        st          <= SERVE;
                    end
                end
                SERVE: begin
                    ball_run <= 1'b0;
                    if (tick) begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt <= CNT_ONE) begin
                            cnt      <= '0;
                            ball_run <= 1'b1;
                            st       <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (miss_1 || miss_2) begin
                        score_1  <= nxt_1;
                        score_2  <= nxt_2;
                        if (miss_1 ^ miss_2)
                            serve_left <= miss_1;
                        ball_run <= 1'b0;
                        cnt      <= PAUSE_CNT;
                        st       <= POINT;
                    end
                end
                POINT: begin
                    if (tick) begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt <= CNT_ONE) begin
                            if (win_1 || win_2) begin
                                cnt       <= '0;
                                game_over <= 1'b1;
                                winner    <= win_2;
                                st        <= GAME_OVER;
                            end else begin
                                ball_reload <= 1'b1;
                                cnt         <= SERVE_CNT;
                                st          <= SERVE;
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    ball_run <= 1'b0;
                    if (start_edge) begin
                        score_1     <= '0;
                        score_2     <= '0;
                        game_over   <= 1'b0;
                        ball_reload <= 1'b1;
                        cnt         <= SERVE_CNT;
                        st          <= SERVE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
